uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single board UART transmitter (console path to the host-side UART monitor) between several on-chip byte producers, e.g. the core's MMIO UART and a debug/trace source.
- Arbitrates at packet level: once a requester wins, it keeps the transmitter until it sends a beat marked last. The console then never interleaves bytes from different sources.
- Provides a one-entry registered output stage toward the UART TX, plus a lock watchdog so a stalled owner cannot hang the console.

Parameters:
- N_REQ, 2, number of requester ports (2..8).
- DATA_WIDTH, 8, byte width per beat.
- LOCK_TIMEOUT, 1024, idle cycles a locked owner may go without sending a beat before its lock is revoked; 0 disables the watchdog.

Ports:
- clock  input  1  single clock; all state is on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- io_in_valid  input  N_REQ  per-requester beat valid.
- io_in_ready  output  N_REQ  per-requester beat accepted.
- io_in_bits  input  N_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- io_in_last  input  N_REQ  beat ends the requester's packet.
- io_out_valid  output  1  byte available for UART TX.
- io_out_ready  input  1  UART TX accepts the byte.
- io_out_bits  output  DATA_WIDTH  byte to transmit.
- io_grant  output  N_REQ  one-hot current lock owner; 0 when IDLE.
- io_busy  output  1  high when state is LOCKED or io_out_valid=1.
- io_timeout  output  1  one-cycle pulse when the watchdog revokes a lock.

Behaviour:
- Reset, asynchronous on reset=0:
  - state=IDLE, rr_ptr=0, owner=0, watchdog count=0.
  - io_out_valid=0, io_out_bits=0, io_grant=0, io_busy=0, io_timeout=0.
  - All io_in_ready=0.
  - Reset asserted mid-packet drops the lock and any held byte. No partial state survives.
- Output stage: one register. The stage can accept a beat this cycle when io_out_valid=0 or io_out_ready=1. A beat accepted on cycle t appears on io_out_valid/io_out_bits at t+1. Full throughput of one beat per cycle is sustained while io_out_ready=1.
- Handshakes follow valid/ready: a beat transfers when io_in_valid[i]&&io_in_ready[i]. io_in_ready is never asserted for more than one requester in a cycle. io_in_ready may depend combinationally on io_in_valid and io_out_ready. io_out_valid, once high, holds with stable io_out_bits until io_out_ready=1.
- IDLE state:
  - The winner is the first i with io_in_valid[i]=1, searching from rr_ptr upward and wrapping modulo N_REQ.
  - If the stage can accept, io_in_ready[winner]=1 and the first beat transfers in the same cycle.
  - First beat has last=1: single-beat packet. Stay IDLE and set rr_ptr=(winner+1) mod N_REQ.
  - First beat has last=0: go to LOCKED with owner=winner and watchdog count=0.
  - No valid requester, or stage full: no transfer and no state change.
- LOCKED state:
  - Only io_in_ready[owner] may assert, subject to stage availability. Other requesters' valid is ignored.
  - io_grant = one-hot(owner).
  - Owner beat with last=1 transfers: go to IDLE, rr_ptr=(owner+1) mod N_REQ.
  - Any owner beat transfers: watchdog count clears.
  - Otherwise the count increments each cycle.
  - Count reaches LOCK_TIMEOUT-1 with no owner beat (LOCK_TIMEOUT>0): go to IDLE, rr_ptr=(owner+1) mod N_REQ, io_timeout=1 for exactly one cycle.
  - The stage stalling (io_out_ready=0) does not advance the watchdog. The count only increments in cycles where the stage could accept and the owner is not valid.
- Simultaneous events: last beat transfer and timeout in the same cycle → the transfer wins and no timeout pulse fires.
- rr_ptr is updated only at packet end or timeout. Ties cannot occur because the search order is fixed from rr_ptr.
- Width rules: owner and rr_ptr are clog2(N_REQ) bits, minimum 1. The watchdog counter is clog2(LOCK_TIMEOUT+1) bits and saturates.

Test Plan:
- Reset: hold reset=0 with all io_in_valid=1 → io_out_valid=0, io_in_ready=0, io_grant=0. Release → first grant goes to requester 0.
- Single-beat round-robin: both requesters continuously offer last=1 beats (req0 0x41, req1 0x42), io_out_ready=1 → output sequence 0x41,0x42,0x41,0x42, one byte per cycle after 1-cycle latency.
- Packet lock: req0 sends "HI\n" (0x48,0x49,0x0A with last on 0x0A) while req1 offers 0xCA → output 0x48,0x49,0x0A,0xCA. io_grant=01 while req0 holds the lock.
- Backpressure: io_out_ready=0 for 5 cycles mid-packet → io_out_bits stable, io_in_ready=0, no lost or duplicated bytes, no timeout pulse.
- Watchdog: LOCK_TIMEOUT=16; req0 sends 0x11 (last=0) then drops valid, req1 valid 0x22 → io_timeout pulses once after 16 idle cycles, then 0x22 appears next.
- Async reset mid-packet: assert reset between cycles during a locked transfer → outputs clear immediately. After release, the arbiter grants from rr_ptr=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX byte stream.
// Holds a lock per packet, registers the output byte, revokes stalled locks.
module uart_tx_arbiter #(
  parameter int N_REQ        = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            io_in_valid,
  output logic [N_REQ-1:0]            io_in_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0] io_in_bits,
  input  logic [N_REQ-1:0]            io_in_last,
  output logic                        io_out_valid,
  input  logic                        io_out_ready,
  output logic [DATA_WIDTH-1:0]       io_out_bits,
  output logic [N_REQ-1:0]            io_grant,
  output logic                        io_busy,
  output logic                        io_timeout
);

  localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW0 = $clog2(LOCK_TIMEOUT + 1);
  localparam int CW  = (CW0 > 0) ? CW0 : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_t;

  state_t                r_state;
  logic [PW-1:0]         r_rr;
  logic [PW-1:0]         r_owner;
  logic [CW-1:0]         r_cnt;
  logic                  r_timeout;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_bits;

  state_t                w_state_nx;
  logic [PW-1:0]         w_rr_nx;
  logic [PW-1:0]         w_owner_nx;
  logic [CW-1:0]         w_cnt_nx;
  logic                  w_to_fire;

  logic                  w_found;
  logic [PW-1:0]         w_win;
  logic [PW-1:0]         w_sel;
  logic                  w_can;
  logic [N_REQ-1:0]      w_ready;
  logic                  w_xfer;
  logic                  w_sel_last;
  logic [DATA_WIDTH-1:0] w_sel_bits;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (int'(p) == N_REQ - 1) ? '0 : p + 1'b1;
  endfunction

  // Downward scan so the requester closest to r_rr wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (io_in_valid[(int'(r_rr) + k) % N_REQ]) begin
        w_found = 1'b1;
        w_win   = PW'((int'(r_rr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    w_can   = !r_out_valid || io_out_ready;
    w_sel   = (r_state == S_LOCKED) ? r_owner : w_win;
    w_ready = '0;
    if (reset && w_can) begin
      if (r_state == S_LOCKED)
        w_ready = ONE << r_owner;
      else if (w_found)
        w_ready = ONE << w_win;
    end
    w_xfer     = |(io_in_valid & w_ready);
    w_sel_last = io_in_last[w_sel];
    w_sel_bits = io_in_bits[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    w_state_nx = r_state;
    w_rr_nx    = r_rr;
    w_owner_nx = r_owner;
    w_cnt_nx   = r_cnt;
    w_to_fire  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          if (w_sel_last) begin
            w_rr_nx = f_inc(w_win);
          end else begin
            w_state_nx = S_LOCKED;
            w_owner_nx = w_win;
            w_cnt_nx   = '0;
          end
        end
      end
      S_LOCKED: begin
        if (w_xfer) begin
          w_cnt_nx = '0;
          if (w_sel_last) begin
            w_state_nx = S_IDLE;
            w_rr_nx    = f_inc(r_owner);
          end
        end else if (w_can && !io_in_valid[r_owner]) begin
          if (LOCK_TIMEOUT > 0 && r_cnt == CNT_LAST) begin
            w_state_nx = S_IDLE;
            w_rr_nx    = f_inc(r_owner);
            w_cnt_nx   = '0;
            w_to_fire  = 1'b1;
          end else if (r_cnt != '1) begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_rr      <= '0;
      r_owner   <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_rr      <= w_rr_nx;
      r_owner   <= w_owner_nx;
      r_cnt     <= w_cnt_nx;
      r_timeout <= w_to_fire;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_bits  <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_bits  <= w_sel_bits;
    end else if (io_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign io_in_ready  = w_ready;
  assign io_out_valid = r_out_valid;
  assign io_out_bits  = r_out_bits;
  assign io_grant     = (r_state == S_LOCKED) ? (ONE << r_owner) : '0;
  assign io_busy      = (r_state == S_LOCKED) || r_out_valid;
  assign io_timeout   = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: round-robin, packet lock,
// backpressure, lock watchdog and asynchronous reset mid-packet.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [15:0] in_bits;
  logic [1:0]  in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_bits;
  logic [1:0]  grant;
  logic        busy;
  logic        tmo;

  int checks;
  int failures;

  uart_tx_arbiter #(
    .N_REQ(2),
    .DATA_WIDTH(8),
    .LOCK_TIMEOUT(16)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .io_in_valid(in_valid),
    .io_in_ready(in_ready),
    .io_in_bits(in_bits),
    .io_in_last(in_last),
    .io_out_valid(out_valid),
    .io_out_ready(out_ready),
    .io_out_bits(out_bits),
    .io_grant(grant),
    .io_busy(busy),
    .io_timeout(tmo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b1;
    in_valid  = 2'b00;
    in_last   = 2'b00;
    in_bits   = 16'h0;
    out_ready = 1'b1;
    #2;
    rst_n    = 1'b0;
    in_valid = 2'b11;
    in_last  = 2'b11;
    in_bits  = {8'h42, 8'h41};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bits", out_bits, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", tmo, 0);

    rst_n = 1'b1;
    #1;
    chk("rr_first_ready", in_ready, 2'b01);
    tick();
    chk("rr_v0", out_valid, 1);
    chk("rr_b0", out_bits, 8'h41);
    chk("rr_ready1", in_ready, 2'b10);
    tick();
    chk("rr_b1", out_bits, 8'h42);
    chk("rr_ready0", in_ready, 2'b01);
    tick();
    chk("rr_b2", out_bits, 8'h41);
    tick();
    chk("rr_b3", out_bits, 8'h42);
    in_valid = 2'b00;
    tick();
    chk("rr_drain_v", out_valid, 0);
    chk("rr_drain_busy", busy, 0);

    in_valid = 2'b11;
    in_last  = 2'b10;
    in_bits  = {8'hCA, 8'h48};
    #1;
    chk("pk_ready0", in_ready, 2'b01);
    tick();
    chk("pk_b0", out_bits, 8'h48);
    chk("pk_grant0", grant, 2'b01);
    chk("pk_busy", busy, 1);
    in_bits = {8'hCA, 8'h49};
    #1;
    chk("pk_ready_lock", in_ready, 2'b01);
    tick();
    chk("pk_b1", out_bits, 8'h49);
    chk("pk_grant1", grant, 2'b01);
    in_bits = {8'hCA, 8'h0A};
    in_last = 2'b11;
    tick();
    chk("pk_b2", out_bits, 8'h0A);
    chk("pk_grant_rel", grant, 2'b00);
    in_valid = 2'b10;
    tick();
    chk("pk_b3", out_bits, 8'hCA);
    chk("pk_v3", out_valid, 1);
    in_valid = 2'b00;
    tick();

    in_valid = 2'b01;
    in_last  = 2'b00;
    in_bits  = {8'h00, 8'h31};
    tick();
    chk("bp_b0", out_bits, 8'h31);
    chk("bp_grant", grant, 2'b01);
    out_ready = 1'b0;
    in_bits   = {8'h00, 8'h32};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_bits", out_bits, 8'h31);
      chk("bp_hold_v", out_valid, 1);
      chk("bp_ready", in_ready, 2'b00);
      chk("bp_timeout", tmo, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_resume_ready", in_ready, 2'b01);
    tick();
    chk("bp_b1", out_bits, 8'h32);
    in_bits = {8'h00, 8'h33};
    in_last = 2'b01;
    tick();
    chk("bp_b2", out_bits, 8'h33);
    chk("bp_grant_rel", grant, 2'b00);
    in_valid = 2'b00;
    tick();

    in_valid = 2'b01;
    in_last  = 2'b00;
    in_bits  = {8'h22, 8'h11};
    tick();
    chk("wd_b0", out_bits, 8'h11);
    chk("wd_grant", grant, 2'b01);
    in_valid = 2'b10;
    in_last  = 2'b10;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("wd_no_pulse", tmo, 0);
      chk("wd_locked", grant, 2'b01);
    end
    tick();
    chk("wd_pulse", tmo, 1);
    chk("wd_grant_rel", grant, 2'b00);
    chk("wd_ready1", in_ready, 2'b10);
    tick();
    chk("wd_pulse_end", tmo, 0);
    chk("wd_b1", out_bits, 8'h22);
    chk("wd_v1", out_valid, 1);
    in_valid = 2'b00;
    tick();

    in_valid = 2'b01;
    in_last  = 2'b01;
    in_bits  = {8'h00, 8'h54};
    tick();
    chk("ar_b0", out_bits, 8'h54);
    in_valid = 2'b10;
    in_last  = 2'b00;
    in_bits  = {8'h55, 8'h00};
    tick();
    chk("ar_b1", out_bits, 8'h55);
    chk("ar_grant", grant, 2'b10);
    in_bits = {8'h56, 8'h00};
    tick();
    chk("ar_b2", out_bits, 8'h56);
    chk("ar_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_bits", out_bits, 0);
    chk("ar_grant_clr", grant, 0);
    chk("ar_busy_clr", busy, 0);
    chk("ar_ready_clr", in_ready, 0);
    #1;
    rst_n    = 1'b1;
    in_valid = 2'b11;
    in_last  = 2'b11;
    in_bits  = {8'hA1, 8'hA0};
    #1;
    chk("ar_rr0", in_ready, 2'b01);
    tick();
    chk("ar_first", out_bits, 8'hA0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
